// File: rtl/avalon_pio_out_dimmer_if.sv
// Avalon-MM slave bus bundle for the dimmable output PIO.
// The master drives the request side and the slave returns readdata combinationally.
interface avalon_pio_out_dimmer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_out_dimmer.sv
// Avalon-MM output PIO with set/clear/toggle aliases, global PWM dimming and
// per-bit blink gating; out_port is registered and driven straight to the pins.
module avalon_pio_out_dimmer #(
  parameter int               WIDTH       = 8,
  parameter int               PWM_BITS    = 8,
  parameter int               PRESCALE    = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_pio_out_dimmer_if.slave s_bus,
  output logic [WIDTH-1:0]     out_port
);

  localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

  logic [WIDTH-1:0]    r_data;
  logic [PWM_BITS:0]   r_duty;
  logic [WIDTH-1:0]    r_mask;
  logic [15:0]         r_div;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [15:0]         r_blink_cnt;
  logic                r_phase;
  logic [WIDTH-1:0]    r_out;

  logic             w_write;
  logic             w_div_write;
  logic             w_tick;
  logic             w_pwm_on;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_out_next;
  logic             w_unused;

  assign w_write     = s_bus.chipselect && !s_bus.write_n;
  assign w_div_write = w_write && (s_bus.address == 3'd6);
  assign w_wd        = s_bus.writedata[WIDTH-1:0];
  assign w_tick      = (r_pre_cnt == PRE_LAST);
  assign w_pwm_on    = r_duty[PWM_BITS] ? 1'b1 : ({1'b0, r_pwm_cnt} < r_duty);
  assign w_unused    = &{1'b0, s_bus.writedata};

  // A masked bit is forced off only during the dark half of the blink period.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out_bit
    assign w_out_next[gi] = r_data[gi] & w_pwm_on & ~(r_mask[gi] & ~r_phase);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data      <= RESET_VALUE;
      r_duty      <= DUTY_FULL;
      r_mask      <= '0;
      r_div       <= '0;
      r_pwm_cnt   <= '0;
      r_pre_cnt   <= '0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_out       <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_out     <= w_out_next;

      if (w_write) begin
        case (s_bus.address)
          3'd0:    r_data <= w_wd;
          3'd1:    r_data <= r_data | w_wd;
          3'd2:    r_data <= r_data & ~w_wd;
          3'd3:    r_data <= r_data ^ w_wd;
          3'd4:    r_duty <= s_bus.writedata[PWM_BITS:0];
          3'd5:    r_mask <= w_wd;
          3'd6:    r_div  <= s_bus.writedata[15:0];
          default: ;
        endcase
      end

      // Restarting the whole blink chain on a divider write keeps blink_cnt
      // below the new divider, so a shrinking divider never overshoots.
      if (w_div_write) begin
        r_pre_cnt   <= '0;
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
        if (r_div == 16'd0) begin
          r_blink_cnt <= '0;
          r_phase     <= 1'b1;
        end else if (w_tick) begin
          if (r_blink_cnt == r_div - 16'd1) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
          end else begin
            r_blink_cnt <= r_blink_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_comb begin
    s_bus.readdata = '0;
    if (reset_n) begin
      case (s_bus.address)
        3'd0:    s_bus.readdata = 32'(r_data);
        3'd4:    s_bus.readdata = 32'(r_duty);
        3'd5:    s_bus.readdata = 32'(r_mask);
        3'd6:    s_bus.readdata = 32'(r_div);
        3'd7:    s_bus.readdata = {30'd0, w_pwm_on, r_phase};
        default: s_bus.readdata = '0;
      endcase
    end
  end

  assign out_port = r_out;

endmodule

// File: tb/tb_avalon_pio_out_dimmer.sv
// Scoreboard bench for avalon_pio_out_dimmer: stimulus queues cycle-tagged
// expectations, a negedge monitor compares out_port/readdata against them.
module tb_avalon_pio_out_dimmer;
  localparam int WIDTH    = 8;
  localparam int PWM_BITS = 8;
  localparam int PRESCALE = 4;

  typedef struct packed {
    int          cyc;
    bit          is_rd;
    logic [31:0] exp;
    logic [95:0] name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  int               rst_cyc = 0;
  exp_t             sb[$];

  avalon_pio_out_dimmer_if bus ();

  avalon_pio_out_dimmer #(
    .WIDTH      (WIDTH),
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_bus   (bus),
    .out_port(out_port)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation is tagged with the cycle it must be observed in.
  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = sb[i].is_rd ? bus.readdata : 32'(out_port);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %0s cyc=%0d got=%h want=%h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %0s missed cyc=%0d", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  function automatic bit pwm_exp(input int k, input int duty, input int r);
    return (((k - 1 - r) % 256) < duty);
  endfunction

  task automatic expect_out(input int k, input logic [7:0] v, input logic [95:0] nm);
    sb.push_back('{cyc: k, is_rd: 1'b0, exp: 32'(v), name: nm});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    $display("WR  cyc=%0d addr=%0d data=%h", cyc, a, d);
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wr_data(input logic [2:0] a, input logic [31:0] d, input logic [7:0] v,
                         input logic [95:0] nm);
    expect_out(cyc + 2, v, nm);
    do_write(a, d);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] v, input logic [95:0] nm);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    sb.push_back('{cyc: cyc, is_rd: 1'b1, exp: v, name: nm});
    $display("RD  cyc=%0d addr=%0d want=%h", cyc, a, v);
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    int c;
    int p;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    reset_n        = 1'b0;

    // Reset: two edges low, then release.
    @(posedge clk);
    #1;
    expect_out(cyc, 8'h00, "rst_out");
    do_read(3'd0, 32'h0, "rst_rd0");
    reset_n = 1'b1;
    rst_cyc = cyc;
    expect_out(cyc, 8'h00, "rst_out2");
    expect_out(cyc + 1, 8'h00, "rst_out3");
    do_read(3'd4, 32'd256, "rst_duty");
    do_read(3'd5, 32'h0, "rst_mask");
    do_read(3'd6, 32'h0, "rst_div");
    do_read(3'd7, 32'h3, "rst_stat");

    // DATA write and alias reads.
    expect_out(cyc + 1, 8'h00, "lag_a5");
    wr_data(3'd0, 32'hA5, 8'hA5, "out_a5");
    do_read(3'd0, 32'hA5, "rd_a5");
    do_read(3'd1, 32'h0, "rd_set");
    do_read(3'd2, 32'h0, "rd_clr");
    do_read(3'd3, 32'h0, "rd_tgl");

    // Set / clear / toggle back to back.
    wr_data(3'd0, 32'hF0, 8'hF0, "out_f0");
    wr_data(3'd1, 32'h0F, 8'hFF, "out_set");
    wr_data(3'd2, 32'h81, 8'h7E, "out_clr");
    wr_data(3'd3, 32'hFF, 8'h81, "out_tgl");
    do_read(3'd0, 32'h81, "rd_tgl_d");

    // Upper writedata bits ignored; STATUS writes ignored.
    wr_data(3'd0, 32'hFFFF_FFFF, 8'hFF, "out_wide");
    do_read(3'd0, 32'hFF, "rd_wide");
    do_write(3'd7, 32'hFFFF_FFFF);
    expect_out(cyc + 1, 8'hFF, "st_out");
    do_read(3'd0, 32'hFF, "st_data");
    do_read(3'd4, 32'd256, "st_duty");
    do_read(3'd5, 32'h0, "st_mask");
    do_read(3'd6, 32'h0, "st_div");

    // PWM duty 64 over one full period.
    c = cyc;
    expect_out(c + 1, 8'hFF, "pwm_pre");
    do_write(3'd4, 32'd64);
    for (int k = c + 2; k <= c + 257; k++)
      expect_out(k, pwm_exp(k, 64, rst_cyc) ? 8'hFF : 8'h00, "pwm64");
    do_read(3'd4, 32'd64, "rd_duty64");
    idle(256);

    // Duty 0 and full duty.
    c = cyc;
    do_write(3'd4, 32'd0);
    for (int k = c + 2; k <= c + 41; k++) expect_out(k, 8'h00, "pwm0");
    idle(40);
    c = cyc;
    do_write(3'd4, 32'd256);
    for (int k = c + 2; k <= c + 41; k++) expect_out(k, 8'hFF, "pwm256");
    idle(40);

    // Blink: PRESCALE=4, DIV=3 gives a 12-clock half period on bit0.
    wr_data(3'd0, 32'h03, 8'h03, "bl_data");
    do_write(3'd5, 32'h01);
    do_read(3'd5, 32'h01, "rd_mask");
    c = cyc;
    do_write(3'd6, 32'd3);
    for (int k = c + 1; k <= c + 41; k++)
      expect_out(k, (k == c + 1 || ((k - c - 2) / 12) % 2 == 0) ? 8'h03 : 8'h02, "blink");
    do_read(3'd6, 32'd3, "rd_div3");
    idle(38);
    for (int k = c + 42; k <= c + 71; k++) expect_out(k, 8'h03, "blink_off");
    do_write(3'd6, 32'd0);
    idle(30);
    do_read(3'd7, 32'h3, "stat_off");

    // Reset mid-blink (dark phase) with DUTY=10.
    do_write(3'd0, 32'hFF);
    do_write(3'd4, 32'd10);
    c = cyc;
    do_write(3'd6, 32'd3);
    idle(16);
    reset_n = 1'b0;
    expect_out(cyc + 1, 8'h00, "mrst_out");
    expect_out(cyc + 2, 8'h00, "mrst_out2");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rst_cyc = cyc;
    do_read(3'd0, 32'h0, "mrst_data");
    do_read(3'd4, 32'd256, "mrst_duty");
    do_read(3'd5, 32'h0, "mrst_mask");
    do_read(3'd6, 32'h0, "mrst_div");
    do_read(3'd7, 32'h3, "mrst_stat");
    p = cyc;
    do_write(3'd0, 32'hFF);
    do_write(3'd4, 32'd10);
    for (int k = p + 3; k <= p + 42; k++)
      expect_out(k, pwm_exp(k, 10, rst_cyc) ? 8'hFF : 8'h00, "pwm_restart");
    idle(41);

    idle(3);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
